// File: rtl/store_buffer_fwd_if.sv
// Store buffer bus bundle: LSU store port, load-forwarding lookup,
// DCache write port and occupancy status.
// Handshake rules, shared by the store port and the DCache port:
//   - The store port accepts a transfer on a rising edge where
//     lsudbus2stb_req && stb2lsudbus_ack. The ack is combinational.
//     The LSU keeps req and its payload steady until it sees ack.
//   - The DCache port transfers the head entry on a rising edge where
//     stb2dcache_req && dcache2stb_ack. The head fields stay stable
//     while req is high and ack is low. An ack while req is low is ignored.
interface store_buffer_fwd_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_SEL_WIDTH = DATA_WIDTH / 8,
  parameter int FIFO_DEPTH     = 8
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                      lsudbus2stb_req;
  logic [ADDR_WIDTH-1:0]     lsudbus2stb_addr;
  logic [DATA_WIDTH-1:0]     lsudbus2stb_wdata;
  logic [BYTE_SEL_WIDTH-1:0] lsudbus2stb_sel_byte;
  logic                      stb2lsudbus_ack;

  logic                      ld_lookup_en;
  logic [ADDR_WIDTH-1:0]     ld_addr;
  logic                      stb2lsu_fwd_hit;
  logic [DATA_WIDTH-1:0]     stb2lsu_fwd_data;
  logic [BYTE_SEL_WIDTH-1:0] stb2lsu_fwd_sel_byte;

  logic                      stb2dcache_req;
  logic                      stb2dcache_w_en;
  logic [ADDR_WIDTH-1:0]     stb2dcache_addr;
  logic [DATA_WIDTH-1:0]     stb2dcache_wdata;
  logic [BYTE_SEL_WIDTH-1:0] stb2dcache_sel_byte;
  logic                      dcache2stb_ack;

  logic                      stb_empty;
  logic                      stb_full;
  logic [CNT_W-1:0]          stb_count;

  // LSU / DCache / load-unit side
  modport master (
    output lsudbus2stb_req, lsudbus2stb_addr, lsudbus2stb_wdata, lsudbus2stb_sel_byte,
    input  stb2lsudbus_ack,
    output ld_lookup_en, ld_addr,
    input  stb2lsu_fwd_hit, stb2lsu_fwd_data, stb2lsu_fwd_sel_byte,
    input  stb2dcache_req, stb2dcache_w_en, stb2dcache_addr, stb2dcache_wdata,
    input  stb2dcache_sel_byte,
    output dcache2stb_ack,
    input  stb_empty, stb_full, stb_count
  );

  // Store buffer side
  modport slave (
    input  lsudbus2stb_req, lsudbus2stb_addr, lsudbus2stb_wdata, lsudbus2stb_sel_byte,
    output stb2lsudbus_ack,
    input  ld_lookup_en, ld_addr,
    output stb2lsu_fwd_hit, stb2lsu_fwd_data, stb2lsu_fwd_sel_byte,
    output stb2dcache_req, stb2dcache_w_en, stb2dcache_addr, stb2dcache_wdata,
    output stb2dcache_sel_byte,
    input  dcache2stb_ack,
    output stb_empty, stb_full, stb_count
  );
endinterface

// File: rtl/store_buffer_fwd.sv
// In-order store buffer: it queues committed stores and drains the head
// entry to the DCache. It can merge a store into the youngest non-head
// entry, and it forwards the youngest matching entry to load lookups.
module store_buffer_fwd #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_SEL_WIDTH = DATA_WIDTH / 8,
  parameter int FIFO_DEPTH     = 8,
  parameter bit COALESCE_EN    = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  store_buffer_fwd_if.slave stb_if
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OFF   = $clog2(BYTE_SEL_WIDTH);

  logic [ADDR_WIDTH-1:0]     addr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]     data_q [FIFO_DEPTH];
  logic [BYTE_SEL_WIDTH-1:0] sel_q  [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]     valid_q, valid_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, young_idx, scan_idx;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      empty, full, coalesce, st_ack, push, pop;

  // Two addresses fall in the same data word when they differ only in byte offset bits.
  function automatic logic word_eq(input logic [ADDR_WIDTH-1:0] a, input logic [ADDR_WIDTH-1:0] b);
    return (a >> OFF) == (b >> OFF);
  endfunction

  // Accept, merge and pop decisions and next-state control values.
  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CNT_W'(FIFO_DEPTH));
    young_idx = wr_ptr_q - PTR_W'(1);
    // The head can be in flight to the DCache. Merging is allowed only when
    // the youngest entry is not the head, that is, with two or more entries.
    coalesce  = COALESCE_EN && (count_q >= CNT_W'(2)) && valid_q[young_idx] &&
                word_eq(addr_q[young_idx], stb_if.lsudbus2stb_addr);
    st_ack    = stb_if.lsudbus2stb_req && (coalesce || !full);
    push      = st_ack && !coalesce;
    pop       = stb_if.dcache2stb_ack && !empty;
    wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d   = count_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
    valid_d   = valid_q;
    if (pop)  valid_d[rd_ptr_q] = 1'b0;
    if (push) valid_d[wr_ptr_q] = 1'b1;
  end

  // Pointers, occupancy and valid bits. All of them clear asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Entry payload. A push writes a fresh entry. A merge overwrites the
  // enabled bytes and ORs the byte enables. The payload has no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= stb_if.lsudbus2stb_addr;
      data_q[wr_ptr_q] <= stb_if.lsudbus2stb_wdata;
      sel_q[wr_ptr_q]  <= stb_if.lsudbus2stb_sel_byte;
    end else if (st_ack) begin
      for (int b = 0; b < BYTE_SEL_WIDTH; b++) begin
        if (stb_if.lsudbus2stb_sel_byte[b])
          data_q[young_idx][8*b +: 8] <= stb_if.lsudbus2stb_wdata[8*b +: 8];
      end
      sel_q[young_idx] <= sel_q[young_idx] | stb_if.lsudbus2stb_sel_byte;
    end
  end

  // Head entry to the DCache, status and store ack. Fields are zero when empty.
  always_comb begin
    stb_if.stb2lsudbus_ack     = st_ack;
    stb_if.stb2dcache_req      = !empty;
    stb_if.stb2dcache_w_en     = !empty;
    stb_if.stb2dcache_addr     = empty ? '0 : addr_q[rd_ptr_q];
    stb_if.stb2dcache_wdata    = empty ? '0 : data_q[rd_ptr_q];
    stb_if.stb2dcache_sel_byte = empty ? '0 : sel_q[rd_ptr_q];
    stb_if.stb_empty           = empty;
    stb_if.stb_full            = full;
    stb_if.stb_count           = count_q;
  end

  // Load forwarding. The scan runs from oldest to youngest, so the last match
  // found is the youngest one. Only registered entries are visible to it.
  always_comb begin
    stb_if.stb2lsu_fwd_hit      = 1'b0;
    stb_if.stb2lsu_fwd_data     = '0;
    stb_if.stb2lsu_fwd_sel_byte = '0;
    scan_idx                    = rd_ptr_q;
    if (stb_if.ld_lookup_en) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        scan_idx = rd_ptr_q + PTR_W'(i);
        if (valid_q[scan_idx] && word_eq(addr_q[scan_idx], stb_if.ld_addr)) begin
          stb_if.stb2lsu_fwd_hit      = 1'b1;
          stb_if.stb2lsu_fwd_data     = data_q[scan_idx];
          stb_if.stb2lsu_fwd_sel_byte = sel_q[scan_idx];
        end
      end
    end
  end
endmodule

// File: tb/tb_store_buffer_fwd.sv
// Bench for store_buffer_fwd. A queue-based reference model tracks the
// buffer contents. A compare process checks every output against the model
// on each falling edge. Directed sequences add hand-computed checks at
// chosen points.
module tb_store_buffer_fwd;
  localparam int AW = 32, DW = 32, SW = 4, DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  store_buffer_fwd_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_SEL_WIDTH(SW), .FIFO_DEPTH(DEPTH)) bus ();

  store_buffer_fwd #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_SEL_WIDTH(SW), .FIFO_DEPTH(DEPTH),
                     .COALESCE_EN(1'b1)) dut (.clk(clk), .rst_n(rst_n), .stb_if(bus.slave));

  // Clock and reset
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] sel;
  } ent_t;
  ent_t mq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_coalesce();
    return (mq.size() >= 2) && ((mq[mq.size()-1].addr >> 2) == (bus.lsudbus2stb_addr >> 2));
  endfunction

  // Reference model. It updates on each rising edge from the inputs of that cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
    end else begin
      logic coal, acc;
      ent_t e;
      coal = model_coalesce();
      acc  = bus.lsudbus2stb_req && (coal || mq.size() < DEPTH);
      if (bus.dcache2stb_ack && mq.size() > 0) void'(mq.pop_front());
      if (acc) begin
        if (coal) begin
          e = mq[mq.size()-1];
          for (int b = 0; b < SW; b++)
            if (bus.lsudbus2stb_sel_byte[b]) e.data[8*b +: 8] = bus.lsudbus2stb_wdata[8*b +: 8];
          e.sel = e.sel | bus.lsudbus2stb_sel_byte;
          mq[mq.size()-1] = e;
        end else begin
          e.addr = bus.lsudbus2stb_addr;
          e.data = bus.lsudbus2stb_wdata;
          e.sel  = bus.lsudbus2stb_sel_byte;
          mq.push_back(e);
        end
      end
    end
  end

  // Scoreboard: compare every output against the model on each falling edge.
  always @(negedge clk) begin
    logic          e_hit;
    logic [DW-1:0] e_fd;
    logic [SW-1:0] e_fs;
    logic          e_ack;
    int            n;
    n     = mq.size();
    e_ack = bus.lsudbus2stb_req && (model_coalesce() || n < DEPTH);
    e_hit = 1'b0; e_fd = '0; e_fs = '0;
    if (bus.ld_lookup_en) begin
      for (int i = n - 1; i >= 0; i--) begin
        if (!e_hit && ((mq[i].addr >> 2) == (bus.ld_addr >> 2))) begin
          e_hit = 1'b1; e_fd = mq[i].data; e_fs = mq[i].sel;
        end
      end
    end
    chk("m_ack",   64'(bus.stb2lsudbus_ack), 64'(e_ack));
    chk("m_req",   64'(bus.stb2dcache_req),  64'(n > 0));
    chk("m_w_en",  64'(bus.stb2dcache_w_en), 64'(n > 0));
    chk("m_addr",  64'(bus.stb2dcache_addr),     n > 0 ? 64'(mq[0].addr) : 64'h0);
    chk("m_wdata", 64'(bus.stb2dcache_wdata),    n > 0 ? 64'(mq[0].data) : 64'h0);
    chk("m_sel",   64'(bus.stb2dcache_sel_byte), n > 0 ? 64'(mq[0].sel)  : 64'h0);
    chk("m_empty", 64'(bus.stb_empty), 64'(n == 0));
    chk("m_full",  64'(bus.stb_full),  64'(n == DEPTH));
    chk("m_count", 64'(bus.stb_count), 64'(n));
    chk("m_hit",   64'(bus.stb2lsu_fwd_hit), 64'(e_hit));
    chk("m_fdata", 64'(bus.stb2lsu_fwd_data), 64'(e_fd));
    chk("m_fsel",  64'(bus.stb2lsu_fwd_sel_byte), 64'(e_fs));
  end

  // Driver tasks. They start and end one time unit after a rising edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_store(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    int n = 0;
    bus.lsudbus2stb_req = 1'b1; bus.lsudbus2stb_addr = a;
    bus.lsudbus2stb_wdata = d;  bus.lsudbus2stb_sel_byte = s;
    @(negedge clk);
    while (!bus.stb2lsudbus_ack && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("store_timeout", 64'(n), 64'(0));
    step();
    bus.lsudbus2stb_req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bus.dcache2stb_ack = 1'b1;
    while (!bus.stb_empty && n < 100) begin step(); n++; end
    if (n >= 100) chk("drain_timeout", 64'(n), 64'(0));
    bus.dcache2stb_ack = 1'b0;
  endtask

  initial begin
    bus.lsudbus2stb_req = 1'b0; bus.lsudbus2stb_addr = '0;
    bus.lsudbus2stb_wdata = '0; bus.lsudbus2stb_sel_byte = '0;
    bus.ld_lookup_en = 1'b0;    bus.ld_addr = '0;
    bus.dcache2stb_ack = 1'b0;
    repeat (2) @(negedge clk);
    // 1: reset values, then idle
    chk("rst_req", 64'(bus.stb2dcache_req), 64'h0);
    chk("rst_empty", 64'(bus.stb_empty), 64'h1);
    step(); rst_n = 1'b1;
    repeat (2) step();
    @(negedge clk);
    chk("idle_count", 64'(bus.stb_count), 64'h0);
    chk("idle_addr", 64'(bus.stb2dcache_addr), 64'h0);
    step();

    // 2: single store held on the DCache port, then acked
    do_store(32'h100, 32'h11223344, 4'hF);
    repeat (5) begin
      @(negedge clk);
      chk("hold_req", 64'(bus.stb2dcache_req), 64'h1);
      chk("hold_addr", 64'(bus.stb2dcache_addr), 64'h100);
      chk("hold_data", 64'(bus.stb2dcache_wdata), 64'h11223344);
      chk("hold_sel", 64'(bus.stb2dcache_sel_byte), 64'hF);
    end
    step(); bus.dcache2stb_ack = 1'b1;
    step(); bus.dcache2stb_ack = 1'b0;
    @(negedge clk);
    chk("pop_empty", 64'(bus.stb_empty), 64'h1);
    step();

    // 3: fill, refused store, refused store while popping, then push and pop together
    for (int i = 0; i < DEPTH; i++) do_store(32'h1000 + 32'(i * 16), 32'hA0 + 32'(i), 4'hF);
    @(negedge clk);
    chk("fill_full", 64'(bus.stb_full), 64'h1);
    chk("fill_count", 64'(bus.stb_count), 64'h8);
    step();
    bus.lsudbus2stb_req = 1'b1; bus.lsudbus2stb_addr = 32'h2000;
    bus.lsudbus2stb_wdata = 32'hBEEF; bus.lsudbus2stb_sel_byte = 4'hF;
    @(negedge clk);
    chk("full_noack", 64'(bus.stb2lsudbus_ack), 64'h0);
    step(); bus.dcache2stb_ack = 1'b1;
    @(negedge clk);
    chk("full_pop_noack", 64'(bus.stb2lsudbus_ack), 64'h0);
    step();
    @(negedge clk);
    chk("after_pop_count", 64'(bus.stb_count), 64'h7);
    chk("after_pop_ack", 64'(bus.stb2lsudbus_ack), 64'h1);
    step(); bus.lsudbus2stb_req = 1'b0; bus.dcache2stb_ack = 1'b0;
    @(negedge clk);
    chk("pushpop_count", 64'(bus.stb_count), 64'h7);
    step();
    drain();

    // 4: coalescing into the youngest (non-head) entry
    do_store(32'h200, 32'h000000AA, 4'h1);
    do_store(32'h204, 32'h00001122, 4'h3);
    do_store(32'h206, 32'hAABB0000, 4'hC);
    bus.ld_lookup_en = 1'b1; bus.ld_addr = 32'h205;
    @(negedge clk);
    chk("coal_count", 64'(bus.stb_count), 64'h2);
    chk("coal_hit", 64'(bus.stb2lsu_fwd_hit), 64'h1);
    chk("coal_data", 64'(bus.stb2lsu_fwd_data), 64'hAABB1122);
    chk("coal_sel", 64'(bus.stb2lsu_fwd_sel_byte), 64'hF);
    chk("coal_head", 64'(bus.stb2dcache_addr), 64'h200);
    step(); bus.ld_lookup_en = 1'b0;
    drain();

    // 5: youngest-match forwarding, miss, same-cycle store invisible
    do_store(32'h300, 32'h11111111, 4'hF);
    do_store(32'h300, 32'h22222222, 4'hF);
    bus.ld_lookup_en = 1'b1; bus.ld_addr = 32'h302;
    @(negedge clk);
    chk("fwd_hit", 64'(bus.stb2lsu_fwd_hit), 64'h1);
    chk("fwd_data", 64'(bus.stb2lsu_fwd_data), 64'h22222222);
    step(); bus.ld_addr = 32'h400;
    @(negedge clk);
    chk("fwd_miss", 64'(bus.stb2lsu_fwd_hit), 64'h0);
    chk("fwd_miss_data", 64'(bus.stb2lsu_fwd_data), 64'h0);
    step();
    bus.ld_addr = 32'h500; bus.lsudbus2stb_req = 1'b1; bus.lsudbus2stb_addr = 32'h500;
    bus.lsudbus2stb_wdata = 32'h55; bus.lsudbus2stb_sel_byte = 4'h1;
    @(negedge clk);
    chk("same_cycle_hit", 64'(bus.stb2lsu_fwd_hit), 64'h0);
    step(); bus.lsudbus2stb_req = 1'b0;
    @(negedge clk);
    chk("next_cycle_hit", 64'(bus.stb2lsu_fwd_hit), 64'h1);
    step(); bus.ld_addr = 32'h300; bus.dcache2stb_ack = 1'b1;
    @(negedge clk);
    chk("popping_head_fwd", 64'(bus.stb2lsu_fwd_data), 64'h22222222);
    step(); bus.dcache2stb_ack = 1'b0; bus.ld_lookup_en = 1'b0;
    drain();

    // 6: asynchronous reset mid-drain, then pointer wrap
    do_store(32'h600, 32'h6, 4'hF);
    do_store(32'h610, 32'h7, 4'hF);
    do_store(32'h620, 32'h8, 4'hF);
    bus.dcache2stb_ack = 1'b1;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", 64'(bus.stb2dcache_req), 64'h0);
    chk("arst_count", 64'(bus.stb_count), 64'h0);
    bus.dcache2stb_ack = 1'b0;
    step(); rst_n = 1'b1;
    step();
    for (int i = 0; i < 2 * DEPTH; i++) begin
      bus.lsudbus2stb_req = 1'b1; bus.lsudbus2stb_addr = 32'h700 + 32'(i * 4);
      bus.lsudbus2stb_wdata = 32'h9000 + 32'(i); bus.lsudbus2stb_sel_byte = 4'hF;
      bus.dcache2stb_ack = 1'b1;
      step();
    end
    bus.lsudbus2stb_req = 1'b0; bus.dcache2stb_ack = 1'b0;
    @(negedge clk);
    chk("wrap_count", 64'(bus.stb_count), 64'h1);
    chk("wrap_head", 64'(bus.stb2dcache_wdata), 64'h900F);
    step();
    drain();
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
